// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the data-memory responder slice:
//            FSM state encoding, bus widths and the RAM index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    // Boot-load, CPU-run and completed phases of the responder.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of word-index bits needed to address a RAM of the given depth.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Brief    : Loader byte stream, CPU data-memory port and run-status signals
//            between the CPU/loader side (master) and the responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    import mem_pkg::*;

    // Boot loader byte stream
    logic              load_valid;
    logic [BYTE_W-1:0] load_data;
    logic              load_ready;

    // CPU memory-stage port
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    // Run control / status
    logic              start;
    logic              done;
    logic [WORD_W-1:0] result_word;

    modport master (
        output load_valid, load_data, mem_addr, mem_wdata, mem_we,
        input  load_ready, mem_rdata, start, done, result_word
    );

    modport slave (
        input  load_valid, load_data, mem_addr, mem_wdata, mem_we,
        output load_ready, mem_rdata, start, done, result_word
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module   : ram_1w1r_async
// Brief    : DEPTH_WORDS x WORD_W RAM, one synchronous write port and one
//            asynchronous read port. Contents are not reset.
// Revision : 1.0 - initial release
// ============================================================================
module ram_1w1r_async
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [IDX_W-1:0]  i_waddr,
    input  wire logic [WORD_W-1:0] i_wdata,
    input  wire logic [IDX_W-1:0]  i_raddr,
    output logic      [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    // Write port: word lands on the rising edge; a same-cycle read sees old data.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Responder end of the CPU data-memory port. Boot-loads the RAM
//            from a little-endian byte stream, releases the CPU with start,
//            serves combinational reads / edge writes, and latches the
//            completion store into result_word with done.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LOAD_WORDS  = 64,
    parameter logic [31:0] DONE_ADDR   = 32'h0000_03FC
) (
    input  wire logic          clk,
    input  wire logic          reset,
    data_mem_responder_if.slave bus
);

    localparam int                IDX_W        = idx_width(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] c_ADDR_LIMIT = WORD_W'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0]  c_LAST_WORD  = IDX_W'(LOAD_WORDS - 1);

    // Registered state
    state_t            r_state;
    logic [1:0]        r_byte_cnt;
    logic [IDX_W-1:0]  r_word_cnt;
    logic [23:0]       r_asm;
    logic              r_load_ready;
    logic              r_start;
    logic              r_done;
    logic [WORD_W-1:0] r_result;

    // Decode
    logic              w_take;
    logic              w_word_done;
    logic              w_last_word;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_cpu_idx;
    logic              w_run_we;
    logic              w_done_store;

    // RAM ports
    logic              w_ram_we;
    logic [IDX_W-1:0]  w_ram_waddr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_rdata;

    assign w_take       = (r_state == LOAD) && bus.load_valid && r_load_ready;
    assign w_word_done  = w_take && (r_byte_cnt == 2'd3);
    assign w_last_word  = w_word_done && (r_word_cnt == c_LAST_WORD);
    assign w_in_range   = (bus.mem_addr < c_ADDR_LIMIT);
    assign w_cpu_idx    = bus.mem_addr[IDX_W+1:2];
    assign w_run_we     = (r_state == RUN) && bus.mem_we;
    assign w_done_store = w_run_we && (bus.mem_addr == DONE_ADDR);

    // Write-port mux: loader owns the port in LOAD, the CPU in RUN, nobody in DONE.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_waddr = w_cpu_idx;
        w_ram_wdata = bus.mem_wdata;
        if (w_word_done) begin
            w_ram_we    = 1'b1;
            w_ram_waddr = r_word_cnt;
            w_ram_wdata = {bus.load_data, r_asm};
        end else if (w_run_we && w_in_range) begin
            w_ram_we    = 1'b1;
        end
    end

    ram_1w1r_async #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_cpu_idx),
        .o_rdata (w_ram_rdata)
    );

    // Out-of-range addresses read as zero rather than aliasing into the RAM.
    assign bus.mem_rdata   = w_in_range ? w_ram_rdata : '0;
    assign bus.load_ready  = r_load_ready;
    assign bus.start       = r_start;
    assign bus.done        = r_done;
    assign bus.result_word = r_result;

    // Phase FSM with byte assembly and registered run/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= LOAD;
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= '0;
            r_asm        <= '0;
            r_load_ready <= 1'b1;
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_take) begin
                        if (r_byte_cnt == 2'd3) begin
                            // Word completed this edge; the RAM write happens in parallel.
                            r_byte_cnt <= 2'd0;
                            r_word_cnt <= r_word_cnt + IDX_W'(1);
                            r_asm      <= '0;
                            if (w_last_word) begin
                                r_state      <= RUN;
                                r_start      <= 1'b1;
                                r_load_ready <= 1'b0;
                            end
                        end else begin
                            case (r_byte_cnt)
                                2'd0:    r_asm[7:0]   <= bus.load_data;
                                2'd1:    r_asm[15:8]  <= bus.load_data;
                                default: r_asm[23:16] <= bus.load_data;
                            endcase
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end
                RUN: begin
                    if (w_done_store) begin
                        r_result <= bus.mem_wdata;
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_start  <= 1'b0;
                    end
                end
                DONE: begin
                    // Held until reset; CPU stores are ignored.
                    r_state <= DONE;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the CPU's memory-stage port: address from ALU, write data, write enable in; read data out.
- Also a boot loader. After reset it fills the RAM from an external byte stream, then releases the CPU with `start`.
- Captures the program's completion store (a write to DONE_ADDR) and flags `done`.
- Sits beside the pipelined RSA CPU in the top level; it is the responder end of the CPU's data-memory interface.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the RAM (power of 2).
- LOAD_WORDS, 64, words loaded at boot (1..DEPTH_WORDS).
- DONE_ADDR, 32'h000003FC, byte address whose store ends the run.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  loader byte valid.
- load_data  in  8  loader byte.
- load_ready  out  1  responder accepts a byte this cycle.
- mem_addr  in  32  CPU byte address (ALUOutM).
- mem_wdata  in  32  CPU store data (WriteDataM).
- mem_we  in  1  CPU store enable (MemWriteM).
- mem_rdata  out  32  read data to CPU (ReadData).
- start  out  1  CPU run enable (drives the CPU start input).
- done  out  1  run finished.
- result_word  out  32  data of the completion store.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, named `reset`.
- Reset values:
  - state=LOAD, byte_cnt=0, word_cnt=0, asm_reg=0.
  - start=0, done=0, result_word=0, load_ready=1 on the cycle after reset.
  - RAM contents are NOT cleared by reset.
- FSM states: LOAD -> RUN -> DONE.
  - LOAD -> RUN when the last loaded word is written.
  - RUN -> DONE on a store to DONE_ADDR.
  - DONE is held until reset.
- LOAD:
  - load_ready=1. A byte is taken when load_valid & load_ready.
  - Bytes assemble little-endian: the first byte goes to bits [7:0], the fourth to [31:24].
  - On the 4th byte, the full word (asm_reg plus the incoming byte) is written to RAM[word_cnt] at that same edge. byte_cnt wraps to 0 and word_cnt increments.
  - When word_cnt==LOAD_WORDS-1 and its 4th byte is taken, next state is RUN.
  - start=1 from the following cycle; no extra byte is accepted.
  - mem_we is ignored in LOAD. mem_rdata still reflects the RAM (don't-care for the CPU).
- RUN:
  - load_ready=0 and load_valid is ignored. start=1.
  - Word index = mem_addr[log2(DEPTH_WORDS)+1:2]; mem_addr[1:0] is ignored (no byte lanes).
  - Read is combinational: mem_rdata = RAM[index] in the same cycle. This matches the CPU latching ReadData into MEM/WB at the next edge.
  - Address is out of range when mem_addr >= 4*DEPTH_WORDS. Such reads return 0 and such writes are dropped.
  - Writes happen on the rising edge when mem_we=1.
  - Read-during-write to the same index returns OLD data in that cycle; the new data is visible the next cycle.
- Completion store (mem_we=1 and mem_addr==DONE_ADDR, exact compare):
  - result_word<=mem_wdata; if DONE_ADDR is in range, the RAM word is written as well.
  - Next cycle: state=DONE, done=1, start=0.
- DONE:
  - start=0 freezes the CPU PC. Further mem_we is ignored; reads stay combinational.
  - done and result_word are held until reset.
- Reset mid-LOAD: the partial word is discarded and loading restarts at word 0, byte 0. Already-written words remain until they are overwritten.
- Reset in RUN or DONE: the block returns to LOAD and start drops on the cycle after reset.
- No combinational path from load_valid to load_ready.

Decomposition:
- Shared package `mem_pkg`:
  - state enum {LOAD, RUN, DONE} (2 bits).
  - WORD_W=32 and BYTE_W=8.
  - localparam function for the index width, clog2(DEPTH_WORDS).
- One natural sub-module, `ram_1w1r_async`: DEPTH_WORDS x 32, synchronous write, asynchronous read.
- The loader assembly and the FSM stay in the top module.

Test Plan:
- Boot with LOAD_WORDS=4: bytes 01,02,03,04, 05..10 -> RAM[0]=32'h04030201, RAM[3]=32'h100F0E0D. start rises exactly 1 cycle after the 16th accepted byte; load_ready=0 thereafter.
- Gapped loader: load_valid toggles 1/0 every cycle -> same RAM image as back-to-back. byte_cnt holds across gaps; start is delayed accordingly.
- RUN read/write:
  - Store 32'hDEADBEEF to 0x08, then read 0x08 next cycle -> mem_rdata=32'hDEADBEEF.
  - Same-cycle read of 0x08 during the write -> old value.
  - Read of 0x0A (misaligned) -> same word as 0x08.
- Out of range (DEPTH_WORDS=256): store to 0x400, then read 0x400 -> 0. RAM[0] is unchanged.
- Completion: store 32'h00000ABC to 0x3FC -> next cycle done=1, start=0, result_word=32'h00000ABC. A later store to 0x3FC with 32'h1 is ignored and result_word is unchanged.
- Reset after 6 of 16 bytes: restart the stream -> RAM[0] holds the new first word, with no stale byte merged in. start stays 0 until 16 new bytes are taken.
